// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared types and defaults for the memory-channel arbiter
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

    // Mirrors the pipeline datapath width.
    localparam int c_xlen         = 32;
    localparam int c_starve_limit = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        G_IR = 2'd0,
        G_DR = 2'd1,
        G_DW = 2'd2
    } grant_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_arbiter_select.sv
`default_nettype none
// ============================================================================
// arb_select : combinational winner selection, data-first with ir starvation guard
// Rev 1.0
// ============================================================================
module arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = c_starve_limit,
    parameter int CNT_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
    input  logic             ir_req_i,
    input  logic             dr_req_i,
    input  logic             dw_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output grant_t           grant_o
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    // With no request pending the result is a don't-care; the caller gates it.
    always_comb begin
        grant_o = G_IR;
        if (ir_req_i && (starve_cnt_i == C_LIMIT)) begin
            grant_o = G_IR;
        end else if (dw_req_i) begin
            grant_o = G_DW;
        end else if (dr_req_i) begin
            grant_o = G_DR;
        end
    end

endmodule : arb_select
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : serialises ir / dr / dw requests onto one memory channel
// Rev 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN         = c_xlen,
    parameter int STARVE_LIMIT = c_starve_limit
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ir_req,
    input  logic [XLEN-1:0]   ir_addr,
    output logic              ir_ready,
    output logic [XLEN-1:0]   ir_data,
    input  logic              dr_req,
    input  logic [XLEN-1:0]   dr_addr,
    output logic              dr_ready,
    output logic [XLEN-1:0]   dr_data,
    input  logic              dw_req,
    input  logic [XLEN-1:0]   dw_addr,
    input  logic [XLEN-1:0]   dw_data,
    input  logic [XLEN/8-1:0] dw_be,
    output logic              dw_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int               CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    state_t              state_q;
    grant_t              grant_q;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic                mem_req_q, mem_we_q;
    logic [XLEN-1:0]     mem_addr_q, mem_wdata_q, rdata_q;
    logic [XLEN/8-1:0]   mem_be_q;
    logic                ir_ready_q, dr_ready_q, dw_ready_q;

    grant_t              w_grant;
    logic                w_any_req;

    assign w_any_req = ir_req | dr_req | dw_req;

    arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_select (
        .ir_req_i     (ir_req),
        .dr_req_i     (dr_req),
        .dw_req_i     (dw_req),
        .starve_cnt_i (starve_cnt_q),
        .grant_o      (w_grant)
    );

    // Counter only moves on IDLE cycles, where arbitration actually happens.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!ir_req || (w_grant == G_IR)) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != C_LIMIT) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= G_IR;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            rdata_q      <= '0;
            ir_ready_q   <= 1'b0;
            dr_ready_q   <= 1'b0;
            dw_ready_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                IDLE: begin
                    if (w_any_req) begin
                        grant_q   <= w_grant;
                        mem_req_q <= 1'b1;
                        state_q   <= GRANT;
                        case (w_grant)
                            G_DW: begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= dw_addr;
                                mem_wdata_q <= dw_data;
                                mem_be_q    <= dw_be;
                            end
                            G_DR: begin
                                mem_we_q    <= 1'b0;
                                mem_addr_q  <= dr_addr;
                                mem_wdata_q <= '0;
                                mem_be_q    <= '1;
                            end
                            default: begin
                                mem_we_q    <= 1'b0;
                                mem_addr_q  <= ir_addr;
                                mem_wdata_q <= '0;
                                mem_be_q    <= '1;
                            end
                        endcase
                    end
                end
                GRANT: begin
                    if (mem_ack) begin
                        mem_req_q  <= 1'b0;
                        rdata_q    <= mem_rdata;
                        ir_ready_q <= (grant_q == G_IR);
                        dr_ready_q <= (grant_q == G_DR);
                        dw_ready_q <= (grant_q == G_DW);
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    ir_ready_q <= 1'b0;
                    dr_ready_q <= 1'b0;
                    dw_ready_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign ir_ready  = ir_ready_q;
    assign dr_ready  = dr_ready_q;
    assign dw_ready  = dw_ready_q;
    assign ir_data   = rdata_q;
    assign dr_data   = rdata_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int XLEN         = 32;
    localparam int STARVE_LIMIT = 4;

    logic              clk;
    logic              reset;
    logic              ir_req, dr_req, dw_req;
    logic [XLEN-1:0]   ir_addr, dr_addr, dw_addr, dw_data;
    logic [XLEN/8-1:0] dw_be;
    logic              ir_ready, dr_ready, dw_ready;
    logic [XLEN-1:0]   ir_data, dr_data;
    logic              mem_req, mem_we, mem_ack;
    logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
    logic [XLEN/8-1:0] mem_be;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ir_req    (ir_req),
        .ir_addr   (ir_addr),
        .ir_ready  (ir_ready),
        .ir_data   (ir_data),
        .dr_req    (dr_req),
        .dr_addr   (dr_addr),
        .dr_ready  (dr_ready),
        .dr_data   (dr_data),
        .dw_req    (dw_req),
        .dw_addr   (dw_addr),
        .dw_data   (dw_data),
        .dw_be     (dw_be),
        .dw_ready  (dw_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ir_req = 0; dr_req = 0; dw_req = 0;
        ir_addr = '0; dr_addr = '0; dw_addr = '0; dw_data = '0; dw_be = '0;
        mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        ir_req = 1; dr_req = 1; dw_req = 1; mem_ack = 1;
        step();
        step();
        checks++;
        if ({mem_req, mem_we, ir_ready, dr_ready, dw_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000", {mem_req, mem_we, ir_ready, dr_ready, dw_ready});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_be, ir_data} !== '0) begin
            errors++;
            $display("FAIL reset_buses: addr=%h wdata=%h be=%h data=%h want all 0", mem_addr, mem_wdata, mem_be, ir_data);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.starve_cnt_q !== '0) begin
            errors++;
            $display("FAIL reset_state: state=%0d cnt=%0d want 0/0", dut.state_q, dut.starve_cnt_q);
        end
        clear_inputs();
        reset = 0;
        step();
    endtask

    task automatic test_single_ir();
        apply_reset();
        ir_req = 1; ir_addr = 32'h100;
        step();                                   // cycle 1
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF) begin
            errors++;
            $display("FAIL ir_issue: req=%b addr=%h we=%b be=%h want 1/100/0/f", mem_req, mem_addr, mem_we, mem_be);
        end
        step();                                   // cycle 2
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || ir_ready !== 1'b0) begin
            errors++;
            $display("FAIL ir_hold: req=%b addr=%h ready=%b want 1/100/0", mem_req, mem_addr, ir_ready);
        end
        step();                                   // cycle 3
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        step();                                   // cycle 4
        mem_ack = 0; mem_rdata = '0;
        checks++;
        if (ir_ready !== 1'b1 || ir_data !== 32'hDEADBEEF || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ir_resp: ready=%b data=%h mem_req=%b want 1/deadbeef/0", ir_ready, ir_data, mem_req);
        end
        ir_req = 0;
        step();                                   // cycle 5
        checks++;
        if (ir_ready !== 1'b0 || ir_data !== 32'hDEADBEEF || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL ir_after: ready=%b data=%h state=%0d want 0/deadbeef/0", ir_ready, ir_data, dut.state_q);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        dw_req = 1; dw_addr = 32'h200; dw_data = 32'h12345678; dw_be = 4'b0011;
        dr_req = 1; dr_addr = 32'h300;
        ir_req = 1; ir_addr = 32'h400;
        step();                                   // cycle 1: dw granted
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 ||
            mem_wdata !== 32'h12345678 || mem_be !== 4'b0011) begin
            errors++;
            $display("FAIL prio_dw: req=%b we=%b addr=%h wdata=%h be=%b want 1/1/200/12345678/0011",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_be);
        end
        mem_ack = 1; mem_rdata = 32'hAAAA0001;
        step();                                   // cycle 2
        mem_ack = 0;
        checks++;
        if ({ir_ready, dr_ready, dw_ready} !== 3'b001) begin
            errors++;
            $display("FAIL prio_dw_ready: got %b want 001", {ir_ready, dr_ready, dw_ready});
        end
        dw_req = 0;
        step();                                   // cycle 3: IDLE
        step();                                   // cycle 4: dr granted
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h300 || mem_be !== 4'hF) begin
            errors++;
            $display("FAIL prio_dr: req=%b we=%b addr=%h be=%h want 1/0/300/f", mem_req, mem_we, mem_addr, mem_be);
        end
        mem_ack = 1; mem_rdata = 32'hBBBB0002;
        step();                                   // cycle 5
        mem_ack = 0;
        checks++;
        if ({ir_ready, dr_ready, dw_ready} !== 3'b010 || dr_data !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL prio_dr_ready: rdy=%b data=%h want 010/bbbb0002", {ir_ready, dr_ready, dw_ready}, dr_data);
        end
        dr_req = 0;
        step();                                   // cycle 6: IDLE
        step();                                   // cycle 7: ir granted
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h400) begin
            errors++;
            $display("FAIL prio_ir: req=%b we=%b addr=%h want 1/0/400", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'hCCCC0003;
        step();                                   // cycle 8
        mem_ack = 0;
        checks++;
        if ({ir_ready, dr_ready, dw_ready} !== 3'b100 || ir_data !== 32'hCCCC0003) begin
            errors++;
            $display("FAIL prio_ir_ready: rdy=%b data=%h want 100/cccc0003", {ir_ready, dr_ready, dw_ready}, ir_data);
        end
        ir_req = 0;
        step();
    endtask

    task automatic test_starvation();
        logic [XLEN-1:0] want_addr;
        logic [2:0]      want_rdy;
        apply_reset();
        ir_req = 1; ir_addr = 32'h400;
        dr_req = 1; dr_addr = 32'h300;
        for (int g = 1; g <= 6; g++) begin
            want_addr = (g == 5) ? 32'h400 : 32'h300;
            want_rdy  = (g == 5) ? 3'b100 : 3'b010;
            step();                               // GRANT
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== want_addr) begin
                errors++;
                $display("FAIL starve_grant%0d: req=%b addr=%h want 1/%h", g, mem_req, mem_addr, want_addr);
            end
            if (g == 4 || g == 5) begin
                checks++;
                if (dut.starve_cnt_q !== ((g == 4) ? 3'd4 : 3'd0)) begin
                    errors++;
                    $display("FAIL starve_cnt%0d: got %0d want %0d", g, dut.starve_cnt_q, (g == 4) ? 4 : 0);
                end
            end
            mem_ack = 1; mem_rdata = XLEN'(g);
            step();                               // DONE
            mem_ack = 0;
            checks++;
            if ({ir_ready, dr_ready, dw_ready} !== want_rdy) begin
                errors++;
                $display("FAIL starve_ready%0d: got %b want %b", g, {ir_ready, dr_ready, dw_ready}, want_rdy);
            end
            step();                               // IDLE
        end
        clear_inputs();
        step();
        step();
        step();
    endtask

    task automatic test_reset_in_grant();
        apply_reset();
        ir_req = 1; ir_addr = 32'h500;
        step();                                   // GRANT
        mem_ack = 1; mem_rdata = 32'h55555555;
        reset = 1;
        step();
        checks++;
        if (mem_req !== 1'b0 || {ir_ready, dr_ready, dw_ready} !== 3'b000 || dut.state_q !== IDLE) begin
            errors++;
            $display("FAIL rst_grant: mem_req=%b rdy=%b state=%0d want 0/000/0",
                     mem_req, {ir_ready, dr_ready, dw_ready}, dut.state_q);
        end
        reset = 0; mem_ack = 0; ir_req = 0;
        step();
        checks++;
        if ({ir_ready, dr_ready, dw_ready} !== 3'b000 || ir_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_grant_after: rdy=%b data=%h want 000/0", {ir_ready, dr_ready, dw_ready}, ir_data);
        end
    endtask

    task automatic test_stray_ack();
        apply_reset();
        mem_ack = 1; mem_rdata = 32'h77777777;
        step();
        mem_ack = 0;
        checks++;
        if (dut.state_q !== IDLE || mem_req !== 1'b0 || {ir_ready, dr_ready, dw_ready} !== 3'b000) begin
            errors++;
            $display("FAIL stray_idle: state=%0d mem_req=%b rdy=%b want 0/0/000",
                     dut.state_q, mem_req, {ir_ready, dr_ready, dw_ready});
        end
        dr_req = 1; dr_addr = 32'h600;
        step();                                   // GRANT
        mem_ack = 1; mem_rdata = 32'h66666666;
        step();                                   // DONE, ack held high as a stray
        dr_req = 0; mem_rdata = 32'h99999999;
        step();
        mem_ack = 0;
        checks++;
        if (dut.state_q !== IDLE || {ir_ready, dr_ready, dw_ready} !== 3'b000 ||
            mem_req !== 1'b0 || dr_data !== 32'h66666666) begin
            errors++;
            $display("FAIL stray_done: state=%0d rdy=%b mem_req=%b data=%h want 0/000/0/66666666",
                     dut.state_q, {ir_ready, dr_ready, dw_ready}, mem_req, dr_data);
        end
    endtask

    task automatic test_back_to_back();
        int ready_cyc[$];
        apply_reset();
        ir_req = 1; ir_addr = 32'h700;
        for (int c = 1; c <= 12; c++) begin
            step();
            mem_ack = mem_req;
            mem_rdata = XLEN'(c);
            if (ir_ready === 1'b1) ready_cyc.push_back(c);
        end
        clear_inputs();
        step();
        step();
        checks++;
        if (ready_cyc.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d strobes want 4", ready_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ready_cyc[i] != 2 + 3 * i) begin
                    errors++;
                    $display("FAIL b2b_cycle%0d: got %0d want %0d", i, ready_cyc[i], 2 + 3 * i);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_single_ir();
        test_priority();
        test_starvation();
        test_reset_in_grant();
        test_stray_ack();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire
